// File: rtl/fir_decim_sat_if.sv
// ---------------------------------------------------------------------------
// fir_decim_sat_if
// Sample-stream bundle between the FIR output and the decimating output stage.
//   din_vld  : input sample enable
//   din      : signed FIR output sample (DIN_W)
//   sync_clr : synchronous frame restart
//   ovf_clr  : synchronous clear of the sticky overflow flag
//   dout     : signed decimated, scaled, saturated sample (DOUT_W)
//   dout_vld : one-cycle strobe, dout updated
//   ovf      : sticky saturation flag
// Modports: master drives the sample side, slave is the decimator.
// ---------------------------------------------------------------------------
interface fir_decim_sat_if #(
    parameter int DIN_W  = 22,
    parameter int DOUT_W = 16
);
    logic                     din_vld;
    logic signed [DIN_W-1:0]  din;
    logic                     sync_clr;
    logic                     ovf_clr;
    logic signed [DOUT_W-1:0] dout;
    logic                     dout_vld;
    logic                     ovf;

    modport master (
        output din_vld, din, sync_clr, ovf_clr,
        input  dout, dout_vld, ovf
    );

    modport slave (
        input  din_vld, din, sync_clr, ovf_clr,
        output dout, dout_vld, ovf
    );
endinterface

// File: rtl/fir_decim_sat.sv
// ---------------------------------------------------------------------------
// fir_decim_sat
// Integrate-and-dump decimator placed after the 6-tap FIR. Sums DEC = 2**LOG2_DEC
// accepted samples, arithmetically shifts the sum right by SHIFT, saturates it to
// DOUT_W bits and emits it with a one-cycle valid strobe.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : fir_decim_sat_if.slave (din_vld, din, sync_clr, ovf_clr -> dout,
//          dout_vld, ovf)
// Configuration macro FIR_DECIM_ROUND_EN:
//   defined     -> round half up before the shift
//   not defined -> truncate toward -inf
// ---------------------------------------------------------------------------
module fir_decim_sat #(
    parameter int DIN_W    = 22,
    parameter int DOUT_W   = 16,
    parameter int LOG2_DEC = 3,
    parameter int SHIFT    = 9
) (
    input  logic           clk,
    input  logic           rst,
    fir_decim_sat_if.slave bus
);
    localparam int DEC   = 1 << LOG2_DEC;
    localparam int ACC_W = DIN_W + LOG2_DEC;
    localparam int EXT_W = ACC_W + 1;
    localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;

    localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DEC - 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic signed [EXT_W-1:0] OUT_MAX  = {{(EXT_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN  = {{(EXT_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
`ifdef FIR_DECIM_ROUND_EN
    localparam logic signed [EXT_W-1:0] HALF_LSB = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
`endif

    // Returns {clamped, word}: value limited to the signed DOUT_W range.
    function automatic logic [DOUT_W:0] sat_word(input logic signed [EXT_W-1:0] v);
        logic [DOUT_W:0] r;
        if (v > OUT_MAX) begin
            r = {1'b1, OUT_MAX[DOUT_W-1:0]};
        end else if (v < OUT_MIN) begin
            r = {1'b1, OUT_MIN[DOUT_W-1:0]};
        end else begin
            r = {1'b0, v[DOUT_W-1:0]};
        end
        return r;
    endfunction

    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
    logic signed [ACC_W-1:0]  acc_r, acc_nxt_s;
    logic signed [DOUT_W-1:0] dout_r, dout_nxt_s;
    logic                     vld_r, vld_nxt_s;
    logic                     ovf_r, ovf_nxt_s;

    logic                     first_s;
    logic                     last_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [EXT_W-1:0]  biased_s;
    logic signed [EXT_W-1:0]  scaled_s;
    logic                     clamp_s;
    logic signed [DOUT_W-1:0] sat_s;

    // Datapath: running sum including the current sample, scaling and saturation.
    always_comb begin
        // A restart makes the incoming sample the first of a fresh frame.
        first_s = bus.sync_clr || (cnt_r == CNT_ZERO);
        if (LOG2_DEC == 0) begin
            last_s = 1'b1;
        end else if (bus.sync_clr) begin
            last_s = 1'b0;
        end else begin
            last_s = (cnt_r == CNT_LAST);
        end
        sum_s = (first_s ? ACC_ZERO : acc_r) + ACC_W'(bus.din);
        // One guard bit so the rounding offset cannot overflow the sum.
`ifdef FIR_DECIM_ROUND_EN
        biased_s = EXT_W'(sum_s) + HALF_LSB;
`else
        biased_s = EXT_W'(sum_s);
`endif
        scaled_s           = biased_s >>> SHIFT;
        {clamp_s, sat_s}   = sat_word(scaled_s);
    end

    // Next-state: phase counter, accumulator, output word, strobe and sticky flag.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        acc_nxt_s  = acc_r;
        dout_nxt_s = dout_r;
        vld_nxt_s  = 1'b0;
        ovf_nxt_s  = ovf_r;
        if (bus.din_vld) begin
            acc_nxt_s = sum_s;
            if (LOG2_DEC == 0) begin
                cnt_nxt_s = CNT_ZERO;
            end else if (bus.sync_clr) begin
                cnt_nxt_s = CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
            if (last_s) begin
                dout_nxt_s = sat_s;
                vld_nxt_s  = 1'b1;
            end else begin
                dout_nxt_s = dout_r;
            end
        end else if (bus.sync_clr) begin
            cnt_nxt_s = CNT_ZERO;
            acc_nxt_s = ACC_ZERO;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // A new clamp wins over a simultaneous clear.
        if (vld_nxt_s && clamp_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            acc_r  <= ACC_ZERO;
            dout_r <= {DOUT_W{1'b0}};
            vld_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            acc_r  <= acc_nxt_s;
            dout_r <= dout_nxt_s;
            vld_r  <= vld_nxt_s;
            ovf_r  <= ovf_nxt_s;
        end
    end

    assign bus.dout     = dout_r;
    assign bus.dout_vld = vld_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_fir_decim_sat.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_sat
// Self-checking bench for fir_decim_sat at default parameters (DEC=8, SHIFT=9,
// DOUT_W=16). A queue-based reference model collects each frame's samples and
// computes the expected word with plain integer arithmetic. Honours
// FIR_DECIM_ROUND_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fir_decim_sat;
    localparam int DIN_W    = 22;
    localparam int DOUT_W   = 16;
    localparam int LOG2_DEC = 3;
    localparam int SHIFT    = 9;
    localparam int DEC      = 1 << LOG2_DEC;
`ifdef FIR_DECIM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam longint OUT_MAX = (64'sd1 <<< (DOUT_W - 1)) - 64'sd1;
    localparam longint OUT_MIN = -(64'sd1 <<< (DOUT_W - 1));
    localparam longint DIN_MAX = (64'sd1 <<< (DIN_W - 1)) - 64'sd1;
    localparam longint DIN_MIN = -(64'sd1 <<< (DIN_W - 1));

    logic clk;
    logic rst;

    fir_decim_sat_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

    fir_decim_sat #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .LOG2_DEC(LOG2_DEC), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks_cnt;
    int     errors_cnt;
    longint frame_q[$];
    longint exp_dout;
    logic   exp_vld;
    logic   exp_ovf;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock cycle, advance the reference model, then check outputs.
    task automatic step(input logic v, input longint d, input logic sc, input logic oc);
        longint sum;
        longint scaled;
        logic   clamp;
        bus.din_vld  = v;
        bus.din      = DIN_W'(d);
        bus.sync_clr = sc;
        bus.ovf_clr  = oc;
        exp_vld = 1'b0;
        clamp   = 1'b0;
        if (sc) frame_q.delete();
        if (v) begin
            frame_q.push_back(d);
            if (frame_q.size() == DEC) begin
                sum = 0;
                foreach (frame_q[i]) sum += frame_q[i];
                if (ROUND) sum += (64'sd1 <<< (SHIFT - 1));
                scaled = sum >>> SHIFT;
                if (scaled > OUT_MAX) begin
                    exp_dout = OUT_MAX; clamp = 1'b1;
                end else if (scaled < OUT_MIN) begin
                    exp_dout = OUT_MIN; clamp = 1'b1;
                end else begin
                    exp_dout = scaled;
                end
                exp_vld = 1'b1;
                frame_q.delete();
            end
        end
        if (exp_vld && clamp) exp_ovf = 1'b1;
        else if (oc)          exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_val("dout_vld", longint'(bus.dout_vld), longint'(exp_vld));
        check_val("dout",     longint'(bus.dout),     exp_dout);
        check_val("ovf",      longint'(bus.ovf),      longint'(exp_ovf));
    endtask

    task automatic frame(input longint d);
        for (int i = 0; i < DEC; i++) step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.din_vld  = 1'b0;
        bus.din      = '0;
        bus.sync_clr = 1'b0;
        bus.ovf_clr  = 1'b0;
        rst = 1'b1;
        #1;
        frame_q.delete();
        exp_dout = 0;
        exp_vld  = 1'b0;
        exp_ovf  = 1'b0;
        check_val("rst_dout",     longint'(bus.dout),     64'sd0);
        check_val("rst_dout_vld", longint'(bus.dout_vld), 64'sd0);
        check_val("rst_ovf",      longint'(bus.ovf),      64'sd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic signed [DIN_W-1:0] rnd;
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b0;
        do_reset();

        // 1: reset mid-frame discards the partial sum.
        for (int i = 0; i < 3; i++) step(1'b1, 64'sd1000, 1'b0, 1'b0);
        do_reset();
        frame(64'sd512);
        check_val("t1_dout", longint'(bus.dout), 64'sd8);
        check_val("t1_ovf",  longint'(bus.ovf),  64'sd0);
        step(1'b0, 64'sd0, 1'b0, 1'b0);

        // 2: small input, rounding decides between 0 and 1.
        frame(64'sd32);
        check_val("t2_dout", longint'(bus.dout), ROUND ? 64'sd1 : 64'sd0);

        // 3: full-scale positive.
        frame(DIN_MAX);
        check_val("t3_dout", longint'(bus.dout), 64'sd32767);
        check_val("t3_ovf",  longint'(bus.ovf),  ROUND ? 64'sd1 : 64'sd0);

        // 4: full-scale negative, ovf_clr alongside a non-clamping frame.
        step(1'b0, 64'sd0, 1'b0, 1'b1);
        frame(DIN_MIN);
        check_val("t4_dout", longint'(bus.dout), -64'sd32768);
        check_val("t4_ovf",  longint'(bus.ovf),  64'sd0);
        step(1'b1, DIN_MIN, 1'b0, 1'b1);
        for (int i = 1; i < DEC; i++) step(1'b1, DIN_MIN, 1'b0, 1'b0);
        check_val("t4b_ovf", longint'(bus.ovf), 64'sd0);

        // 5: restart mid-frame with gaps.
        for (int i = 0; i < 5; i++) step(1'b1, 64'sd100, 1'b0, 1'b0);
        step(1'b1, 64'sd512, 1'b1, 1'b0);
        for (int i = 0; i < DEC - 1; i++) begin
            int gap;
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) step(1'b0, 64'sd0, 1'b0, 1'b0);
            step(1'b1, 64'sd512, 1'b0, 1'b0);
        end
        check_val("t5_dout", longint'(bus.dout), 64'sd8);

        // 6: sticky ovf survives a clean frame, then clears.
        frame(DIN_MAX);
        frame(64'sd0);
        check_val("t6_dout", longint'(bus.dout), 64'sd0);
        check_val("t6_ovf",  longint'(bus.ovf),  ROUND ? 64'sd1 : 64'sd0);
        step(1'b0, 64'sd0, 1'b0, 1'b1);
        check_val("t6_clr",  longint'(bus.ovf),  64'sd0);

        // sync_clr without a sample, then clamp and ovf_clr together.
        for (int i = 0; i < 3; i++) step(1'b1, 64'sd7, 1'b0, 1'b0);
        step(1'b0, 64'sd0, 1'b1, 1'b0);
        for (int i = 0; i < DEC - 1; i++) step(1'b1, DIN_MAX, 1'b0, 1'b0);
        step(1'b1, DIN_MAX, 1'b0, 1'b1);

        // Random stimulus: large values, gaps, occasional restarts and clears.
        for (int n = 0; n < 600; n++) begin
            logic v, sc, oc;
            rnd = DIN_W'($urandom);
            if ($urandom_range(3, 0) == 0) rnd = ($urandom_range(1, 0) == 1) ? DIN_W'(DIN_MAX) : DIN_W'(DIN_MIN);
            v  = ($urandom_range(3, 0) != 0);
            sc = ($urandom_range(39, 0) == 0);
            oc = ($urandom_range(15, 0) == 0);
            step(v, longint'(rnd), sc, oc);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
